// File: rtl/pm_share_arbiter.sv
// Round-robin owner of the shared poly_mult; 0-cycle mux/valid path, grant 1 cycle after request, ownership held while busy.
// Optional PM_ARB_WATCHDOG_EN: revokes a grant whose multiplication never returns valid within TIMEOUT cycles.
module pm_share_arbiter #(
  parameter parameter_set = "hqc128",
  parameter int RAMWIDTH  = 128,
  parameter int M         = (parameter_set == "hqc128") ? 15 : 16,
  parameter int WT_W      = (parameter_set == "hqc256") ? 9 : 8,
  parameter int WBX       = 128,
  parameter int ADDR_W    = 9,
  parameter int RES_W     = 8,
  parameter int LOGW      = 16,
  parameter int TIMEOUT   = 65535
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // requester 0: decapsulation path
  input  logic                r0_req_i,
  output logic                r0_gnt_o,
  input  logic                r0_start_i,
  input  logic                r0_rd_dout_i,
  input  logic                r0_add_wr_en_i,
  input  logic [M-1:0]        r0_loc_in_i,
  input  logic [WT_W-1:0]     r0_weight_i,
  input  logic [WBX-1:0]      r0_mux_word_0_i,
  input  logic [WBX-1:0]      r0_mux_word_1_i,
  input  logic [RES_W-1:0]    r0_addr_result_i,
  input  logic [RES_W-1:0]    r0_add_addr_i,
  input  logic [RAMWIDTH-1:0] r0_add_in_i,
  output logic                r0_valid_o,
  output logic [WBX-1:0]      r0_dout_o,
  output logic [LOGW-1:0]     r0_loc_addr_o,
  output logic [ADDR_W-1:0]   r0_addr_0_o,
  output logic [ADDR_W-1:0]   r0_addr_1_o,
  // requester 1: re-encryption path
  input  logic                r1_req_i,
  output logic                r1_gnt_o,
  input  logic                r1_start_i,
  input  logic                r1_rd_dout_i,
  input  logic                r1_add_wr_en_i,
  input  logic [M-1:0]        r1_loc_in_i,
  input  logic [WT_W-1:0]     r1_weight_i,
  input  logic [WBX-1:0]      r1_mux_word_0_i,
  input  logic [WBX-1:0]      r1_mux_word_1_i,
  input  logic [RES_W-1:0]    r1_addr_result_i,
  input  logic [RES_W-1:0]    r1_add_addr_i,
  input  logic [RAMWIDTH-1:0] r1_add_in_i,
  output logic                r1_valid_o,
  output logic [WBX-1:0]      r1_dout_o,
  output logic [LOGW-1:0]     r1_loc_addr_o,
  output logic [ADDR_W-1:0]   r1_addr_0_o,
  output logic [ADDR_W-1:0]   r1_addr_1_o,
  // shared poly_mult
  output logic                pm_start_o,
  output logic                pm_rd_dout_o,
  output logic                pm_add_wr_en_o,
  output logic [M-1:0]        pm_loc_in_o,
  output logic [WT_W-1:0]     pm_weight_o,
  output logic [WBX-1:0]      pm_mux_word_0_o,
  output logic [WBX-1:0]      pm_mux_word_1_o,
  output logic [RES_W-1:0]    pm_addr_result_o,
  output logic [RES_W-1:0]    pm_add_addr_o,
  output logic [RAMWIDTH-1:0] pm_add_in_o,
  input  logic                pm_valid_i,
  input  logic [WBX-1:0]      pm_dout_i,
  input  logic [LOGW-1:0]     pm_loc_addr_i,
  input  logic [ADDR_W-1:0]   pm_addr_0_i,
  input  logic [ADDR_W-1:0]   pm_addr_1_i,
  output logic                err_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;

  state_t state_q;
  logic   last_q;
  logic   busy_q;
  logic   err_q;
  logic   rel_q;   // owner dropped req mid-multiplication; waiting for valid
  logic   own_req;
  logic   req0_ok;
  logic   req1_ok;

`ifdef PM_ARB_WATCHDOG_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       blk_q;  // watchdog-revoked requester must drop req before re-arbitrating
  assign req0_ok = r0_req_i & ~blk_q[0];
  assign req1_ok = r1_req_i & ~blk_q[1];
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign req0_ok = r0_req_i;
  assign req1_ok = r1_req_i;
`endif

  assign r0_gnt_o   = (state_q == OWN0);
  assign r1_gnt_o   = (state_q == OWN1);
  assign r0_valid_o = pm_valid_i & (state_q == OWN0);
  assign r1_valid_o = pm_valid_i & (state_q == OWN1);
  assign own_req    = (state_q == OWN1) ? r1_req_i : r0_req_i;
  assign err_o      = err_q;

  assign r0_dout_o     = pm_dout_i;
  assign r1_dout_o     = pm_dout_i;
  assign r0_loc_addr_o = pm_loc_addr_i;
  assign r1_loc_addr_o = pm_loc_addr_i;
  assign r0_addr_0_o   = pm_addr_0_i;
  assign r1_addr_0_o   = pm_addr_0_i;
  assign r0_addr_1_o   = pm_addr_1_i;
  assign r1_addr_1_o   = pm_addr_1_i;

  // Strobes are suppressed once the owner has released, so a late start cannot relaunch
  always_comb begin
    pm_start_o       = 1'b0;
    pm_rd_dout_o     = 1'b0;
    pm_add_wr_en_o   = 1'b0;
    pm_loc_in_o      = '0;
    pm_weight_o      = '0;
    pm_mux_word_0_o  = '0;
    pm_mux_word_1_o  = '0;
    pm_addr_result_o = '0;
    pm_add_addr_o    = '0;
    pm_add_in_o      = '0;
    case (state_q)
      OWN0: begin
        pm_start_o       = r0_start_i & r0_req_i & ~rel_q;
        pm_rd_dout_o     = r0_rd_dout_i & r0_req_i & ~rel_q;
        pm_add_wr_en_o   = r0_add_wr_en_i & r0_req_i & ~rel_q;
        pm_loc_in_o      = r0_loc_in_i;
        pm_weight_o      = r0_weight_i;
        pm_mux_word_0_o  = r0_mux_word_0_i;
        pm_mux_word_1_o  = r0_mux_word_1_i;
        pm_addr_result_o = r0_addr_result_i;
        pm_add_addr_o    = r0_add_addr_i;
        pm_add_in_o      = r0_add_in_i;
      end
      OWN1: begin
        pm_start_o       = r1_start_i & r1_req_i & ~rel_q;
        pm_rd_dout_o     = r1_rd_dout_i & r1_req_i & ~rel_q;
        pm_add_wr_en_o   = r1_add_wr_en_i & r1_req_i & ~rel_q;
        pm_loc_in_o      = r1_loc_in_i;
        pm_weight_o      = r1_weight_i;
        pm_mux_word_0_o  = r1_mux_word_0_i;
        pm_mux_word_1_o  = r1_mux_word_1_i;
        pm_addr_result_o = r1_addr_result_i;
        pm_add_addr_o    = r1_add_addr_i;
        pm_add_in_o      = r1_add_in_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rel_q   <= 1'b0;
`ifdef PM_ARB_WATCHDOG_EN
      cnt_q   <= '0;
      blk_q   <= '0;
`endif
    end else begin
      // a start and a done in the same cycle leave the instance busy
      busy_q <= pm_start_o | (busy_q & ~pm_valid_i);
      if ((r0_start_i && state_q != OWN0) || (r1_start_i && state_q != OWN1))
        err_q <= 1'b1;
`ifdef PM_ARB_WATCHDOG_EN
      if (!r0_req_i) blk_q[0] <= 1'b0;
      if (!r1_req_i) blk_q[1] <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          rel_q <= 1'b0;
          if (req0_ok && (!req1_ok || last_q)) state_q <= OWN0;
          else if (req1_ok)                    state_q <= OWN1;
        end
        OWN0, OWN1: begin
          if (!own_req || rel_q) begin
            if (!busy_q || pm_valid_i) begin
              state_q <= DRAIN;
              last_q  <= (state_q == OWN1);
              rel_q   <= 1'b0;
            end else begin
              err_q <= 1'b1;
              rel_q <= 1'b1;
            end
          end
`ifdef PM_ARB_WATCHDOG_EN
          if (pm_valid_i || !busy_q) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q                   <= DRAIN;
            last_q                    <= (state_q == OWN1);
            busy_q                    <= 1'b0;
            err_q                     <= 1'b1;
            rel_q                     <= 1'b0;
            cnt_q                     <= '0;
            blk_q[state_q == OWN1]    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        DRAIN:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
